// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight GPR producers, selects forwarding stage or stalls ID.
// Optional macro SCOREBOARD_HILO_EN adds HI/LO tracking alongside the GPRs.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int FW_DEPTH = 2,
    localparam int AW = $clog2(NREG),
    localparam int FW = $clog2(FW_DEPTH + 1),
    localparam int CW = $clog2(NREG + 3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic [FW-1:0] issue_lat,
    input  logic          issue_hi,
    input  logic          issue_lo,
    input  logic          flush,
    input  logic          rs_rena,
    input  logic          rt_rena,
    input  logic [AW-1:0] rsc,
    input  logic [AW-1:0] rtc,
    input  logic          hi_rena,
    input  logic          lo_rena,
    output logic          stall_out,
    output logic [FW-1:0] rs_fw_sel,
    output logic [FW-1:0] rt_fw_sel,
    output logic [FW-1:0] hi_fw_sel,
    output logic [FW-1:0] lo_fw_sel,
    output logic [CW-1:0] busy_count
);
    localparam int HI = NREG;
    localparam int LO = NREG + 1;
    localparam int NE = NREG + 2;
    localparam logic [FW-1:0] LAST = FW'(FW_DEPTH);

    logic [NE-1:0] valid_q, valid_d, issue_vec;
    logic [FW-1:0] stage_q [NE];
    logic [FW-1:0] stage_d [NE];
    logic [FW-1:0] rem_q [NE];
    logic [FW-1:0] rem_d [NE];
    logic [FW-1:0] issue_rem;
    logic [CW-1:0] busy_q, busy_d;
    logic          eff_issue;
    logic          rs_pend, rt_pend, hi_pend, lo_pend;

    // {pending, select}: a hit whose result is not yet forwardable stalls instead of selecting
    function automatic logic [FW:0] lookup(input logic hit, input logic [FW-1:0] stage,
                                           input logic [FW-1:0] rem);
        if (!hit) return '0;
        if (rem != '0) return {1'b1, {FW{1'b0}}};
        return {1'b0, stage};
    endfunction

    always_comb begin
        {rs_pend, rs_fw_sel} = lookup(rs_rena && rsc != '0 && valid_q[rsc], stage_q[rsc], rem_q[rsc]);
        {rt_pend, rt_fw_sel} = lookup(rt_rena && rtc != '0 && valid_q[rtc], stage_q[rtc], rem_q[rtc]);
`ifdef SCOREBOARD_HILO_EN
        {hi_pend, hi_fw_sel} = lookup(hi_rena && valid_q[HI], stage_q[HI], rem_q[HI]);
        {lo_pend, lo_fw_sel} = lookup(lo_rena && valid_q[LO], stage_q[LO], rem_q[LO]);
`else
        hi_pend   = 1'b0;
        lo_pend   = 1'b0;
        hi_fw_sel = '0;
        lo_fw_sel = '0;
`endif
        stall_out = rs_pend | rt_pend | hi_pend | lo_pend;
    end

`ifndef SCOREBOARD_HILO_EN
    logic unused_hilo;
    assign unused_hilo = ^{issue_hi, issue_lo, hi_rena, lo_rena, valid_q[HI], valid_q[LO],
                           stage_q[HI], stage_q[LO], rem_q[HI], rem_q[LO]};
`endif

    always_comb begin
        eff_issue = issue_valid & ~stall_out & ~flush;
        if (issue_lat == '0)
            issue_rem = '0;
        else if (issue_lat > LAST)
            issue_rem = LAST - 1'b1;
        else
            issue_rem = issue_lat - 1'b1;
        issue_vec = '0;
        for (int i = 1; i < NREG; i++)
            issue_vec[i] = eff_issue && (issue_rd == AW'(i));
`ifdef SCOREBOARD_HILO_EN
        issue_vec[HI] = eff_issue && issue_hi;
        issue_vec[LO] = eff_issue && issue_lo;
`endif
    end

    // Issue overrides aging, so the youngest producer always owns the entry
    always_comb begin
        busy_d = '0;
        for (int i = 0; i < NE; i++) begin
            valid_d[i] = 1'b0;
            stage_d[i] = '0;
            rem_d[i]   = '0;
            if (issue_vec[i]) begin
                valid_d[i] = 1'b1;
                stage_d[i] = FW'(1);
                rem_d[i]   = issue_rem;
            end else if (valid_q[i] && stage_q[i] != LAST) begin
                valid_d[i] = 1'b1;
                stage_d[i] = stage_q[i] + 1'b1;
                rem_d[i]   = (rem_q[i] == '0) ? '0 : rem_q[i] - 1'b1;
            end
            busy_d = busy_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NE; i++) begin
                stage_q[i] <= '0;
                rem_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NE; i++) begin
                stage_q[i] <= stage_d[i];
                rem_q[i]   <= rem_d[i];
            end
        end
    end

    assign busy_count = busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against an age/latency model.
module tb_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int FW_DEPTH = 2;
    localparam int AW = $clog2(NREG);
    localparam int FW = $clog2(FW_DEPTH + 1);
    localparam int CW = $clog2(NREG + 3);
    localparam int HI = NREG;
    localparam int LO = NREG + 1;
    localparam int NE = NREG + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_hi, issue_lo, flush;
    logic [AW-1:0] issue_rd, rsc, rtc;
    logic [FW-1:0] issue_lat;
    logic          rs_rena, rt_rena, hi_rena, lo_rena;
    logic          stall_out;
    logic [FW-1:0] rs_fw_sel, rt_fw_sel, hi_fw_sel, lo_fw_sel;
    logic [CW-1:0] busy_count;

    int checks = 0;
    int failures = 0;

    // Model: a producer is known by cycles elapsed since issue and its effective latency
    bit m_valid [NE];
    int m_age [NE];
    int m_lat [NE];
    bit exp_stall;

    hazard_scoreboard #(.NREG(NREG), .FW_DEPTH(FW_DEPTH)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_lat(issue_lat), .issue_hi(issue_hi), .issue_lo(issue_lo), .flush(flush),
        .rs_rena(rs_rena), .rt_rena(rt_rena), .rsc(rsc), .rtc(rtc),
        .hi_rena(hi_rena), .lo_rena(lo_rena), .stall_out(stall_out),
        .rs_fw_sel(rs_fw_sel), .rt_fw_sel(rt_fw_sel), .hi_fw_sel(hi_fw_sel),
        .lo_fw_sel(lo_fw_sel), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = '0; issue_lat = '0; issue_hi = 0; issue_lo = 0; flush = 0;
        rs_rena = 0; rt_rena = 0; rsc = '0; rtc = '0; hi_rena = 0; lo_rena = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_age[i] = 0; m_lat[i] = 0;
        end
    endtask

    function automatic int clamp_lat(input int l);
        if (l < 1) return 1;
        if (l > FW_DEPTH) return FW_DEPTH;
        return l;
    endfunction

    // Forwardable once the producer's age has reached its latency
    task automatic expect_src(input bit en, input int idx, output int sel, output bit pend);
        sel = 0; pend = 0;
        if (en && idx != 0 && m_valid[idx]) begin
            if (m_age[idx] < m_lat[idx]) pend = 1;
            else sel = m_age[idx];
        end
    endtask

    task automatic model_check();
        int s; bit p; int cnt;
        exp_stall = 0;
        expect_src(rs_rena, int'(rsc), s, p);
        if (p) exp_stall = 1; else check("rs_fw", int'(rs_fw_sel), s);
        expect_src(rt_rena, int'(rtc), s, p);
        if (p) exp_stall = 1; else check("rt_fw", int'(rt_fw_sel), s);
`ifdef SCOREBOARD_HILO_EN
        expect_src(hi_rena, HI, s, p);
        if (p) exp_stall = 1; else check("hi_fw", int'(hi_fw_sel), s);
        expect_src(lo_rena, LO, s, p);
        if (p) exp_stall = 1; else check("lo_fw", int'(lo_fw_sel), s);
`else
        check("hi_fw_off", int'(hi_fw_sel), 0);
        check("lo_fw_off", int'(lo_fw_sel), 0);
`endif
        check("stall", int'(stall_out), int'(exp_stall));
        cnt = 0;
        for (int i = 0; i < NE; i++) cnt += int'(m_valid[i]);
        check("busy", int'(busy_count), cnt);
    endtask

    task automatic model_issue(input int idx);
        m_valid[idx] = 1; m_age[idx] = 1; m_lat[idx] = clamp_lat(int'(issue_lat));
    endtask

    task automatic model_step();
        bit eff;
        eff = issue_valid && !exp_stall && !flush;
        for (int i = 0; i < NE; i++) begin
            if (m_valid[i]) begin
                m_age[i]++;
                if (m_age[i] > FW_DEPTH) m_valid[i] = 0;
            end
        end
        if (eff && issue_rd != '0) model_issue(int'(issue_rd));
`ifdef SCOREBOARD_HILO_EN
        if (eff && issue_hi) model_issue(HI);
        if (eff && issue_lo) model_issue(LO);
`endif
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        to_neg();
        finish_cycle();
    endtask

    task automatic drain();
        idle();
        repeat (FW_DEPTH + 1) cycle();
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        to_neg();
        check("rst_stall", int'(stall_out), 0);
        check("rst_busy", int'(busy_count), 0);
        rst = 0;
        @(posedge clk); #1;

        // ALU result: forward from EX, then MEM, then register file
        issue_valid = 1; issue_rd = 5; issue_lat = 1;
        cycle();
        idle(); rs_rena = 1; rsc = 5;
        to_neg(); check("alu_stall", int'(stall_out), 0); check("alu_fw1", int'(rs_fw_sel), 1); finish_cycle();
        to_neg(); check("alu_fw2", int'(rs_fw_sel), 2); finish_cycle();
        to_neg(); check("alu_fw0", int'(rs_fw_sel), 0); check("alu_busy0", int'(busy_count), 0); finish_cycle();

        // Load-use: one stall cycle, then forward from MEM
        idle(); issue_valid = 1; issue_rd = 8; issue_lat = 2;
        cycle();
        idle(); rt_rena = 1; rtc = 8;
        to_neg(); check("ld_stall", int'(stall_out), 1); finish_cycle();
        to_neg(); check("ld_release", int'(stall_out), 0); check("ld_fw2", int'(rt_fw_sel), 2); finish_cycle();
        drain();

        // Youngest producer wins over the older stage-2 copy
        idle(); issue_valid = 1; issue_rd = 3; issue_lat = 1;
        cycle();
        issue_lat = 2;
        cycle();
        idle(); rs_rena = 1; rsc = 3;
        to_neg(); check("young_stall", int'(stall_out), 1); finish_cycle();
        drain();

        // Non-issues: rd=0, flushed, and issued while stalled
        idle(); issue_valid = 1; issue_rd = 0; issue_lat = 1;
        cycle();
        to_neg(); check("rd0_busy", int'(busy_count), 0); finish_cycle();
        idle(); issue_valid = 1; issue_rd = 9; issue_lat = 2; flush = 1;
        cycle();
        idle(); issue_valid = 1; issue_rd = 8; issue_lat = 2;
        cycle();
        idle(); rt_rena = 1; rtc = 8; issue_valid = 1; issue_rd = 10; issue_lat = 1;
        to_neg(); check("held_stall", int'(stall_out), 1); finish_cycle();
        idle(); rs_rena = 1; rsc = 9; rt_rena = 1; rtc = 10;
        to_neg();
        check("noissue_stall", int'(stall_out), 0);
        check("noissue_busy", int'(busy_count), 1);
        finish_cycle();
        drain();

        // HI producer with load latency
        idle(); issue_valid = 1; issue_hi = 1; issue_rd = 0; issue_lat = 2;
        cycle();
        idle(); hi_rena = 1;
`ifdef SCOREBOARD_HILO_EN
        to_neg(); check("hi_stall", int'(stall_out), 1); finish_cycle();
        to_neg(); check("hi_fw2", int'(hi_fw_sel), 2); finish_cycle();
`else
        to_neg(); check("hi_nostall", int'(stall_out), 0); check("hi_fw0", int'(hi_fw_sel), 0); finish_cycle();
`endif
        drain();

        // Asynchronous reset in the middle of a stall
        idle(); issue_valid = 1; issue_rd = 8; issue_lat = 2;
        cycle();
        idle(); rt_rena = 1; rtc = 8;
        to_neg();
        check("pre_rst_stall", int'(stall_out), 1);
        #1 rst = 1;
        #1;
        check("arst_stall", int'(stall_out), 0);
        check("arst_busy", int'(busy_count), 0);
        check("arst_fw", int'(rt_fw_sel), 0);
        model_reset();
        idle();
        #1 rst = 0;
        @(posedge clk); #1;

        // Random traffic over a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd    = AW'($urandom_range(0, 7));
            issue_lat   = FW'($urandom_range(0, 3));
            issue_hi    = ($urandom_range(0, 5) == 0);
            issue_lo    = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            rs_rena     = $urandom_range(0, 1);
            rt_rena     = $urandom_range(0, 1);
            rsc         = AW'($urandom_range(0, 7));
            rtc         = AW'($urandom_range(0, 7));
            hi_rena     = ($urandom_range(0, 3) == 0);
            lo_rena     = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
